// File: rtl/spi_sclk_gen_if.sv
// rtl/spi_sclk_gen_if.sv - config, start/done handshake and SCLK/strobe bundle for spi_sclk_gen
// i_hold is present only when SPI_SCLK_HOLD_EN is defined.
interface spi_sclk_gen_if #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 5
);
  logic             i_cfg_load;
  logic [DIV_W-1:0] i_cfg_div;
  logic             i_cfg_cpol;
  logic             i_cfg_cpha;
  logic [CNT_W-1:0] i_cfg_pulses;
  logic             i_start;
`ifdef SPI_SCLK_HOLD_EN
  logic             i_hold;
`endif
  logic             o_busy;
  logic             o_done;
  logic             o_sclk;
  logic             o_sample_stb;
  logic             o_shift_stb;

  modport master (
`ifdef SPI_SCLK_HOLD_EN
    output i_hold,
`endif
    output i_cfg_load, i_cfg_div, i_cfg_cpol, i_cfg_cpha, i_cfg_pulses, i_start,
    input  o_busy, o_done, o_sclk, o_sample_stb, o_shift_stb
  );

  modport slave (
`ifdef SPI_SCLK_HOLD_EN
    input  i_hold,
`endif
    input  i_cfg_load, i_cfg_div, i_cfg_cpol, i_cfg_cpha, i_cfg_pulses, i_start,
    output o_busy, o_done, o_sclk, o_sample_stb, o_shift_stb
  );
endinterface

// File: rtl/spi_sclk_gen.sv
// rtl/spi_sclk_gen.sv - SPI SCLK burst generator with CPOL/CPHA sample/shift strobes
// Optional burst freeze input via SPI_SCLK_HOLD_EN.
module spi_sclk_gen #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 5
) (
  input  logic          i_clk,
  input  logic          i_rst,
  spi_sclk_gen_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    TAIL = 2'd2
  } state_t;

  state_t           state_q, state_n;
  logic [DIV_W-1:0] div_q, div_n;
  logic             cpol_q, cpol_n;
  logic             cpha_q, cpha_n;
  logic [CNT_W-1:0] pulses_q, pulses_n;
  logic [DIV_W-1:0] fast_q, fast_n;
  logic [CNT_W:0]   edge_q, edge_n;
  logic             sclk_q, sclk_n;
  logic             sample_q, sample_n;
  logic             shift_q, shift_n;
  logic             done_q, done_n;

  logic             hold_act;
  logic             cfg_take;
  logic [DIV_W-1:0] half_m1;
  logic [CNT_W-1:0] n_eff;
  logic [CNT_W:0]   last_idx;
  logic             lead;

`ifdef SPI_SCLK_HOLD_EN
  assign hold_act = bus.i_hold;
`else
  assign hold_act = 1'b0;
`endif

  // A load in the same idle cycle as start must already shape that burst.
  assign cfg_take = (state_q == IDLE) && bus.i_cfg_load;
  assign div_n    = cfg_take ? bus.i_cfg_div    : div_q;
  assign cpol_n   = cfg_take ? bus.i_cfg_cpol   : cpol_q;
  assign cpha_n   = cfg_take ? bus.i_cfg_cpha   : cpha_q;
  assign pulses_n = cfg_take ? bus.i_cfg_pulses : pulses_q;

  assign half_m1  = (div_n < DIV_W'(2)) ? '0 : (div_n >> 1) - DIV_W'(1);
  assign n_eff    = (pulses_n == '0) ? CNT_W'(1) : pulses_n;
  assign last_idx = {n_eff, 1'b0} - (CNT_W+1)'(1);
  assign lead     = ~edge_q[0];

  always_comb begin
    state_n  = state_q;
    fast_n   = fast_q;
    edge_n   = edge_q;
    sclk_n   = sclk_q;
    sample_n = 1'b0;
    shift_n  = 1'b0;
    done_n   = 1'b0;
    case (state_q)
      IDLE: begin
        sclk_n = cpol_n;
        if (bus.i_start) begin
          state_n = RUN;
          fast_n  = half_m1;
          edge_n  = '0;
        end
      end
      RUN: begin
        if (!hold_act) begin
          if (fast_q == '0) begin
            sclk_n   = ~sclk_q;
            edge_n   = edge_q + (CNT_W+1)'(1);
            fast_n   = half_m1;
            sample_n = lead ^ cpha_q;
            shift_n  = ~(lead ^ cpha_q);
            if (edge_q == last_idx) begin
              state_n = TAIL;
            end
          end else begin
            fast_n = fast_q - DIV_W'(1);
          end
        end
      end
      TAIL: begin
        if (!hold_act) begin
          if (fast_q == '0) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            fast_n = fast_q - DIV_W'(1);
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      div_q    <= DIV_W'(2);
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      pulses_q <= CNT_W'(8);
      fast_q   <= '0;
      edge_q   <= '0;
      sclk_q   <= 1'b0;
      sample_q <= 1'b0;
      shift_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_n;
      div_q    <= div_n;
      cpol_q   <= cpol_n;
      cpha_q   <= cpha_n;
      pulses_q <= pulses_n;
      fast_q   <= fast_n;
      edge_q   <= edge_n;
      sclk_q   <= sclk_n;
      sample_q <= sample_n;
      shift_q  <= shift_n;
      done_q   <= done_n;
    end
  end

  assign bus.o_busy       = (state_q != IDLE);
  assign bus.o_done       = done_q;
  assign bus.o_sclk       = sclk_q;
  assign bus.o_sample_stb = sample_q;
  assign bus.o_shift_stb  = shift_q;

endmodule

// File: tb/tb_spi_sclk_gen.sv
// tb/tb_spi_sclk_gen.sv - self-checking bench for spi_sclk_gen (hold cases under SPI_SCLK_HOLD_EN)
module tb_spi_sclk_gen;
  localparam int DIV_W = 8;
  localparam int CNT_W = 5;

  logic i_clk = 1'b0;
  logic i_rst;

  spi_sclk_gen_if #(.DIV_W(DIV_W), .CNT_W(CNT_W)) bus ();

  spi_sclk_gen #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  int cur_div;
  bit cur_cpol;
  bit cur_cpha;
  int cur_pulses;

  typedef struct {
    int div;
    bit cpol;
    bit cpha;
    int pulses;
    int exp_first;
    int exp_done;
    int exp_n;
  } vec_t;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] outs();
    return {bus.o_busy, bus.o_done, bus.o_sclk, bus.o_sample_stb, bus.o_shift_stb};
  endfunction

  task automatic set_defaults();
    cur_div = 2; cur_cpol = 1'b0; cur_cpha = 1'b0; cur_pulses = 8;
  endtask

  // Offsets d are cycles after the start edge; the reference tracks burst progress in clock
  // cycles (frozen while held) and derives edges from progress = k*H, k = 1..2N.
  task automatic run_burst(input int div, input bit cpol, input bit cpha, input int pulses,
                           input bit load, input int inj_d, input int hold_lo, input int hold_hi,
                           input int rst_d, output int done_d, output int first_d,
                           output int n_samp, output int n_shift);
    int h, n, len, p, k;
    bit lvl, hold_now, edge_m, dn, samp, fin;
    logic [4:0] exp_o, got_o;
    if (load) begin
      cur_div = div; cur_cpol = cpol; cur_cpha = cpha; cur_pulses = pulses;
      bus.i_cfg_load   = 1'b1;
      bus.i_cfg_div    = 8'(div);
      bus.i_cfg_cpol   = cpol;
      bus.i_cfg_cpha   = cpha;
      bus.i_cfg_pulses = 5'(pulses);
    end
    bus.i_start = 1'b1;
    h   = (cur_div < 2) ? 1 : cur_div / 2;
    n   = (cur_pulses == 0) ? 1 : cur_pulses;
    len = (2 * n + 1) * h;
    p = 0; lvl = cur_cpol; fin = 1'b0;
    done_d = -1; first_d = -1; n_samp = 0; n_shift = 0;
    @(negedge i_clk);
    bus.i_start = 1'b0; bus.i_cfg_load = 1'b0;
    for (int d = 1; !fin; d++) begin
      hold_now = (d >= hold_lo) && (d <= hold_hi);
`ifdef SPI_SCLK_HOLD_EN
      bus.i_hold = hold_now;
`else
      hold_now = 1'b0;
`endif
      if (d == inj_d) begin
        bus.i_start = 1'b1; bus.i_cfg_load = 1'b1; bus.i_cfg_div = 8'd2;
        bus.i_cfg_cpol = ~cur_cpol; bus.i_cfg_pulses = 5'd1;
      end
      if (d == rst_d) i_rst = 1'b1;
      @(negedge i_clk);
      bus.i_start = 1'b0; bus.i_cfg_load = 1'b0;
      got_o = outs();
      if (d == rst_d) begin
        i_rst = 1'b0;
        set_defaults();
        check("abort_reset_outputs", int'(got_o), 0);
        fin = 1'b1;
      end else begin
        edge_m = 1'b0; dn = 1'b0;
        if (p < len && !hold_now) begin
          p++;
          edge_m = (p % h == 0) && (p / h <= 2 * n);
          dn = (p == len);
        end
        k = p / h;
        samp = edge_m && ((k % 2 == 1) != cur_cpha);
        if (edge_m) lvl = ~lvl;
        exp_o = {p < len, dn, lvl, samp, edge_m && !samp};
        check("burst_cycle", int'(got_o), int'(exp_o));
        if (got_o[3] && done_d < 0) done_d = d;
        if ((got_o[1] || got_o[0]) && first_d < 0) first_d = d;
        n_samp  += int'(got_o[1]);
        n_shift += int'(got_o[0]);
        if (dn) fin = 1'b1;
      end
    end
`ifdef SPI_SCLK_HOLD_EN
    bus.i_hold = 1'b0;
`endif
  endtask

  task automatic check_idle(input string name);
    @(negedge i_clk);
    check(name, int'(outs()), int'({2'b00, cur_cpol, 2'b00}));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int dd, fd, ns, nh;
    vec_t tbl[8];
    tbl[0] = '{8,   1'b0, 1'b0, 8,  4,   68,  8};
    tbl[1] = '{0,   1'b0, 1'b0, 1,  1,   3,   1};
    tbl[2] = '{4,   1'b1, 1'b1, 2,  2,   10,  2};
    tbl[3] = '{6,   1'b0, 1'b0, 3,  3,   21,  3};
    tbl[4] = '{1,   1'b0, 1'b1, 0,  1,   3,   1};
    tbl[5] = '{7,   1'b1, 1'b0, 2,  3,   15,  2};
    tbl[6] = '{2,   1'b0, 1'b0, 31, 1,   63,  31};
    tbl[7] = '{255, 1'b0, 1'b1, 1,  127, 381, 1};

    i_rst = 1'b1;
    bus.i_cfg_load = 1'b0; bus.i_cfg_div = '0; bus.i_cfg_cpol = 1'b0;
    bus.i_cfg_cpha = 1'b0; bus.i_cfg_pulses = '0; bus.i_start = 1'b0;
`ifdef SPI_SCLK_HOLD_EN
    bus.i_hold = 1'b0;
`endif
    set_defaults();
    repeat (3) @(negedge i_clk);
    check("reset_outputs", int'(outs()), 0);
    i_rst = 1'b0;
    check_idle("idle_after_reset");

    // Reset configuration: div=2, N=8 -> H=1, done at 17.
    run_burst(0, 1'b0, 1'b0, 0, 1'b0, 0, 0, -1, 0, dd, fd, ns, nh);
    check("default_cfg_done", dd, 17);
    check("default_cfg_first_edge", fd, 1);
    check("default_cfg_samples", ns, 8);
    check_idle("default_cfg_idle");

    for (int i = 0; i < 8; i++) begin
      run_burst(tbl[i].div, tbl[i].cpol, tbl[i].cpha, tbl[i].pulses, 1'b1, 0, 0, -1, 0,
                dd, fd, ns, nh);
      check($sformatf("vec%0d_done", i), dd, tbl[i].exp_done);
      check($sformatf("vec%0d_first_edge", i), fd, tbl[i].exp_first);
      check($sformatf("vec%0d_samples", i), ns, tbl[i].exp_n);
      check($sformatf("vec%0d_shifts", i), nh, tbl[i].exp_n);
      check_idle($sformatf("vec%0d_idle", i));
    end

    // Start in the done cycle is accepted and the next burst follows without a gap.
    run_burst(4, 1'b0, 1'b1, 1, 1'b1, 0, 0, -1, 0, dd, fd, ns, nh);
    check("chain_a_done", dd, 6);
    run_burst(0, 1'b0, 1'b0, 0, 1'b0, 0, 0, -1, 0, dd, fd, ns, nh);
    check("chain_b_done", dd, 6);
    check_idle("chain_idle");

    // cpol change while idle moves sclk on the next cycle.
    bus.i_cfg_load = 1'b1; bus.i_cfg_div = 8'd4; bus.i_cfg_cpol = 1'b1;
    bus.i_cfg_cpha = 1'b0; bus.i_cfg_pulses = 5'd2;
    cur_div = 4; cur_cpol = 1'b1; cur_cpha = 1'b0; cur_pulses = 2;
    @(negedge i_clk);
    bus.i_cfg_load = 1'b0;
    check("cpol_idle_move", int'(bus.o_sclk), 1);
    check_idle("cpol_idle_hold");

    // Start/load ignored mid-burst, then reset aborts with no done.
    run_burst(8, 1'b0, 1'b0, 8, 1'b1, 5, 0, -1, 20, dd, fd, ns, nh);
    check("abort_no_done", dd, -1);
    for (int i = 0; i < 3; i++) check_idle("post_abort_idle");
    run_burst(0, 1'b0, 1'b0, 0, 1'b0, 0, 0, -1, 0, dd, fd, ns, nh);
    check("post_abort_default_done", dd, 17);
    check_idle("post_abort_burst_idle");

`ifdef SPI_SCLK_HOLD_EN
    run_burst(4, 1'b0, 1'b0, 1, 1'b1, 0, 3, 5, 0, dd, fd, ns, nh);
    check("hold_first_edge", fd, 2);
    check("hold_done", dd, 9);
    check_idle("hold_idle");
`endif

    for (int i = 0; i < 25; i++) begin
      int r_div, r_pul, r_lo, r_len;
      bit r_cpol, r_cpha, r_load;
      r_div  = int'($urandom_range(0, 20));
      r_pul  = int'($urandom_range(0, 31));
      r_cpol = 1'($urandom_range(0, 1));
      r_cpha = 1'($urandom_range(0, 1));
      r_load = ($urandom_range(0, 3) != 0);
      r_lo   = int'($urandom_range(1, 40));
      r_len  = int'($urandom_range(0, 6));
      run_burst(r_div, r_cpol, r_cpha, r_pul, r_load, 0, r_lo, r_lo + r_len - 1, 0,
                dd, fd, ns, nh);
      check("rand_sample_shift_balance", ns, nh);
      if ($urandom_range(0, 1) == 1) check_idle("rand_idle");
    end
    check_idle("final_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
